// File: rtl/vpu_pkg.sv
// vpu_pkg: shared defaults, FSM state encoding and the symmetric saturation
// helper for the variable-node processing array.
// Optional feature macro used by the array: VPU_SAT_CNT_EN (lane clamp counter).
package vpu_pkg;

    // Default geometry of the array
    localparam int N_LANE_DEF  = 36;
    localparam int W_LLR_DEF   = 6;
    localparam int W_MSG_DEF   = 6;
    localparam int MAX_DEG_DEF = 8;
    localparam int W_SUM_DEF   = 10;

    // Width of the optional clamp counter
    localparam int SAT_CNT_W = 16;

    // Column controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } vpu_state_e;

    // Clamp a sign-extended accumulator value to +/-(2^(w_msg-1)-1).
    // The most negative code is deliberately excluded so the message range is
    // symmetric and negation downstream can never overflow.
    function automatic logic signed [31:0] sat_sym(input logic signed [31:0] val,
                                                   input int                 w_msg);
        logic signed [31:0] lim;
        lim = (32'sd1 << (w_msg - 1)) - 32'sd1;
        if (val > lim) begin
            return lim;
        end else if (val < -lim) begin
            return -lim;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/vpu_lane.sv
// vpu_lane: datapath of one variable-node lane. Holds the c2v edge buffer,
// the posterior accumulator, the extrinsic subtract-saturate and the hard
// decision. Sequencing (when to load, write and read) comes from vpu_array.
// Optional feature macro: VPU_SAT_CNT_EN adds the clamp_o flag.
module vpu_lane
    import vpu_pkg::*;
#(
    parameter  int W_LLR   = W_LLR_DEF,
    parameter  int W_MSG   = W_MSG_DEF,
    parameter  int MAX_DEG = MAX_DEG_DEF,
    parameter  int W_SUM   = W_SUM_DEF,
    localparam int W_IDX   = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [W_LLR-1:0] llr_i,
    input  logic             wr_en_i,
    input  logic [W_IDX-1:0] idx_i,
    input  logic [W_MSG-1:0] c2v_i,
    input  logic             rd_en_i,
    output logic [W_MSG-1:0] v2c_o,
    output logic             hd_o
`ifdef VPU_SAT_CNT_EN
    ,
    output logic             clamp_o
`endif
);

    logic [W_SUM-1:0] sum_q;
    logic [W_SUM-1:0] sum_d;
    logic [W_MSG-1:0] buf_q [MAX_DEG];

    logic [W_SUM-1:0] llr_ext;
    logic [W_SUM-1:0] c2v_ext;
    logic [W_MSG-1:0] rd_msg;
    logic [W_SUM-1:0] rd_ext;
    logic [W_SUM:0]   diff;
    logic [31:0]      sat_in;
    logic [31:0]      sat_val;

    // Sign extension of the incoming LLR and c2v message to accumulator width
    assign llr_ext = {{(W_SUM - W_LLR){llr_i[W_LLR-1]}}, llr_i};
    assign c2v_ext = {{(W_SUM - W_MSG){c2v_i[W_MSG-1]}}, c2v_i};

    // Extrinsic value: posterior minus this edge's own c2v, one guard bit wide
    assign rd_msg  = buf_q[idx_i];
    assign rd_ext  = {{(W_SUM - W_MSG){rd_msg[W_MSG-1]}}, rd_msg};
    assign diff    = {sum_q[W_SUM-1], sum_q} - {rd_ext[W_SUM-1], rd_ext};
    assign sat_in  = {{(32 - W_SUM - 1){diff[W_SUM]}}, diff};
    assign sat_val = sat_sym($signed(sat_in), W_MSG);

    assign v2c_o = rd_en_i ? W_MSG'(sat_val) : '0;
    assign hd_o  = sum_q[W_SUM-1];

`ifdef VPU_SAT_CNT_EN
    assign clamp_o = rd_en_i & (sat_val != sat_in);
`endif

    // Accumulator next state: load the LLR on start, add each accepted c2v
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves it unassigned would otherwise infer a latch.
        sum_d = sum_q;
        if (load_i) begin
            sum_d = llr_ext;
        end else if (wr_en_i) begin
            sum_d = sum_q + c2v_ext;
        end
    end

    // Accumulator and edge buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: state registers take non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            sum_q <= '0;
            // NOTE: the edge buffer is cleared on reset so a column aborted
            // mid-accumulation leaves no stale c2v behind; this keeps it in
            // flops rather than a RAM macro, which is fine at MAX_DEG entries.
            for (int e = 0; e < MAX_DEG; e++) begin
                buf_q[e] <= '0;
            end
        end else begin
            sum_q <= sum_d;
            if (wr_en_i) begin
                buf_q[idx_i] <= c2v_i;
            end
        end
    end

endmodule

// File: rtl/vpu_array.sv
// vpu_array: N_LANE variable-node lanes sharing one column controller.
// A column is: start (latch deg, load LLRs) -> deg c2v beats -> deg v2c beats
// -> done pulse. Both message streams use valid/ready handshakes.
// Optional feature macro: VPU_SAT_CNT_EN adds the 16-bit sat_cnt output.
module vpu_array
    import vpu_pkg::*;
#(
    parameter  int N_LANE  = N_LANE_DEF,
    parameter  int W_LLR   = W_LLR_DEF,
    parameter  int W_MSG   = W_MSG_DEF,
    parameter  int MAX_DEG = MAX_DEG_DEF,
    parameter  int W_SUM   = W_SUM_DEF,
    localparam int W_DEG   = $clog2(MAX_DEG + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [W_DEG-1:0]        deg,
    input  logic [N_LANE*W_LLR-1:0] llr_in,
    input  logic                    c2v_vld,
    output logic                    c2v_rdy,
    input  logic [N_LANE*W_MSG-1:0] c2v_in,
    output logic                    v2c_vld,
    input  logic                    v2c_rdy,
    output logic [N_LANE*W_MSG-1:0] v2c_out,
    output logic [W_DEG-1:0]        v2c_idx,
    output logic [N_LANE-1:0]       hd_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
`ifdef VPU_SAT_CNT_EN
    ,
    output logic [SAT_CNT_W-1:0]    sat_cnt
`endif
);

    localparam int               W_IDX   = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1;
    localparam logic [W_DEG-1:0] ONE     = W_DEG'(1);
    localparam logic [W_DEG-1:0] DEG_MAX = W_DEG'(MAX_DEG);

    vpu_state_e       state_q;
    vpu_state_e       state_d;
    logic [W_DEG-1:0] cnt_q;
    logic [W_DEG-1:0] cnt_d;
    logic [W_DEG-1:0] deg_q;
    logic [W_DEG-1:0] deg_d;
    logic             err_q;
    logic             err_d;
    logic             done_q;
    logic             done_d;

    logic             deg_legal;
    logic             last_beat;
    logic             load;
    logic             c2v_hs;
    logic             v2c_hs;

    assign deg_legal = (deg != '0) && (deg <= DEG_MAX);
    assign last_beat = (cnt_q == deg_q - ONE);

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign err  = err_q;

    // Controller next state and handshake outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deg_d   = deg_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        c2v_hs  = 1'b0;
        v2c_hs  = 1'b0;
        c2v_rdy = 1'b0;
        v2c_vld = 1'b0;
        v2c_idx = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (deg_legal) begin
                        load    = 1'b1;
                        deg_d   = deg;
                        cnt_d   = '0;
                        state_d = ST_ACC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ACC: begin
                c2v_rdy = 1'b1;
                if (c2v_vld) begin
                    c2v_hs = 1'b1;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = ST_OUT;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            ST_OUT: begin
                v2c_vld = 1'b1;
                v2c_idx = cnt_q;
                if (v2c_rdy) begin
                    v2c_hs = 1'b1;
                    if (last_beat) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset aborts any column without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            deg_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deg_q   <= deg_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef VPU_SAT_CNT_EN
    logic [N_LANE-1:0]    lane_clamp;
    logic [SAT_CNT_W-1:0] clamp_pop;
    logic [SAT_CNT_W:0]   sat_sum;
    logic [SAT_CNT_W-1:0] sat_cnt_q;
    logic [SAT_CNT_W-1:0] sat_cnt_d;

    assign sat_cnt = sat_cnt_q;

    // Clamp counter: add this beat's clamped lanes, stick at all-ones
    always_comb begin
        clamp_pop = '0;
        for (int l = 0; l < N_LANE; l++) begin
            clamp_pop = clamp_pop + SAT_CNT_W'(lane_clamp[l]);
        end
        sat_sum   = {1'b0, sat_cnt_q} + {1'b0, clamp_pop};
        sat_cnt_d = sat_cnt_q;
        if (load) begin
            sat_cnt_d = '0;
        end else if (v2c_hs) begin
            sat_cnt_d = sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
        end
    end

    // Clamp counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end
`endif

    // One datapath per lane; all lanes share cnt as write and read index
    for (genvar g = 0; g < N_LANE; g++) begin : g_lane
        vpu_lane #(
            .W_LLR   (W_LLR),
            .W_MSG   (W_MSG),
            .MAX_DEG (MAX_DEG),
            .W_SUM   (W_SUM)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load_i  (load),
            .llr_i   (llr_in[g*W_LLR +: W_LLR]),
            .wr_en_i (c2v_hs),
            .idx_i   (cnt_q[W_IDX-1:0]),
            .c2v_i   (c2v_in[g*W_MSG +: W_MSG]),
            .rd_en_i (v2c_vld),
            .v2c_o   (v2c_out[g*W_MSG +: W_MSG]),
            .hd_o    (hd_out[g])
`ifdef VPU_SAT_CNT_EN
            ,
            .clamp_o (lane_clamp[g])
`endif
        );
    end

endmodule

// File: tb/tb_vpu_array.sv
// tb_vpu_array: directed-vector bench for vpu_array. Lanes 0 and 1 carry
// hand-computed columns, all other lanes carry zeros. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_vpu_array;

    localparam int N_LANE  = 36;
    localparam int W_LLR   = 6;
    localparam int W_MSG   = 6;
    localparam int MAX_DEG = 8;
    localparam int W_SUM   = 10;
    localparam int W_DEG   = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [W_DEG-1:0]        deg;
    logic [N_LANE*W_LLR-1:0] llr_in;
    logic                    c2v_vld;
    logic                    c2v_rdy;
    logic [N_LANE*W_MSG-1:0] c2v_in;
    logic                    v2c_vld;
    logic                    v2c_rdy;
    logic [N_LANE*W_MSG-1:0] v2c_out;
    logic [W_DEG-1:0]        v2c_idx;
    logic [N_LANE-1:0]       hd_out;
    logic                    busy;
    logic                    done;
    logic                    err;
`ifdef VPU_SAT_CNT_EN
    logic [15:0]             sat_cnt;
`endif

    vpu_array #(
        .N_LANE  (N_LANE),
        .W_LLR   (W_LLR),
        .W_MSG   (W_MSG),
        .MAX_DEG (MAX_DEG),
        .W_SUM   (W_SUM)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .deg     (deg),
        .llr_in  (llr_in),
        .c2v_vld (c2v_vld),
        .c2v_rdy (c2v_rdy),
        .c2v_in  (c2v_in),
        .v2c_vld (v2c_vld),
        .v2c_rdy (v2c_rdy),
        .v2c_out (v2c_out),
        .v2c_idx (v2c_idx),
        .hd_out  (hd_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
`ifdef VPU_SAT_CNT_EN
        ,
        .sat_cnt (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Column description used by run_column
    int col_deg;
    int llr0;
    int llr1;
    int c0[8];
    int c1[8];
    int e0[8];
    int e1[8];
    int hd0;
    int hd1;
    int exp_sat;
    int stall_idx;
    int stall_len;
    bit start_in_out;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic signed [31:0] lane_v2c(input int lane);
        logic signed [W_MSG-1:0] s;
        s = v2c_out[lane*W_MSG +: W_MSG];
        return 32'(s);
    endfunction

    // Drive one full column and check every v2c beat, hd, done and latency
    task automatic run_column(input string tag);
        int t0;
        int stalls;
        llr_in  = '0;
        c2v_in  = '0;
        v2c_rdy = 1'b1;
        llr_in[0 +: W_LLR]     = W_LLR'(llr0);
        llr_in[W_LLR +: W_LLR] = W_LLR'(llr1);
        deg   = W_DEG'(col_deg);
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
        check({tag, " busy_acc"}, busy, 1);
        check({tag, " c2v_rdy_acc"}, c2v_rdy, 1);
        check({tag, " v2c_vld_acc"}, v2c_vld, 0);
        for (int k = 0; k < col_deg; k++) begin
            c2v_vld = 1'b1;
            c2v_in[0 +: W_MSG]     = W_MSG'(c0[k]);
            c2v_in[W_MSG +: W_MSG] = W_MSG'(c1[k]);
            tick();
        end
        c2v_vld = 1'b0;
        c2v_in  = '0;
        check({tag, " c2v_rdy_drop"}, c2v_rdy, 0);
        stalls = 0;
        for (int k = 0; k < col_deg; k++) begin
            check($sformatf("%s v2c_vld[%0d]", tag, k), v2c_vld, 1);
            check($sformatf("%s idx[%0d]", tag, k), v2c_idx, k);
            check($sformatf("%s lane0[%0d]", tag, k), lane_v2c(0), e0[k]);
            check($sformatf("%s lane1[%0d]", tag, k), lane_v2c(1), e1[k]);
            check($sformatf("%s lane_last[%0d]", tag, k), lane_v2c(N_LANE-1), 0);
            check($sformatf("%s hd0[%0d]", tag, k), hd_out[0], hd0);
            check($sformatf("%s hd1[%0d]", tag, k), hd_out[1], hd1);
            check($sformatf("%s done_early[%0d]", tag, k), done, 0);
            if (k == stall_idx) begin
                repeat (stall_len) begin
                    v2c_rdy = 1'b0;
                    tick();
                    stalls++;
                    check($sformatf("%s stall_vld[%0d]", tag, stalls), v2c_vld, 1);
                    check($sformatf("%s stall_idx[%0d]", tag, stalls), v2c_idx, k);
                    check($sformatf("%s stall_lane0[%0d]", tag, stalls), lane_v2c(0), e0[k]);
                    check($sformatf("%s stall_lane1[%0d]", tag, stalls), lane_v2c(1), e1[k]);
                end
            end
            v2c_rdy = 1'b1;
            if (start_in_out && k == 1) begin
                start = 1'b1;
                deg   = W_DEG'(2);
                llr_in[0 +: W_LLR] = W_LLR'(30);
            end
            tick();
            start = 1'b0;
        end
        check({tag, " done"}, done, 1);
        check({tag, " busy_idle"}, busy, 0);
        check({tag, " v2c_vld_idle"}, v2c_vld, 0);
        check({tag, " err_none"}, err, 0);
        check({tag, " latency"}, cyc - t0, 2*col_deg + 1 + stalls);
        check({tag, " hd0_after"}, hd_out[0], hd0);
        check({tag, " hd1_after"}, hd_out[1], hd1);
`ifdef VPU_SAT_CNT_EN
        check({tag, " sat_cnt"}, sat_cnt, exp_sat);
`endif
        tick();
        check({tag, " done_pulse"}, done, 0);
        check({tag, " busy_stay_idle"}, busy, 0);
        check({tag, " hd0_held"}, hd_out[0], hd0);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        deg     = '0;
        llr_in  = '0;
        c2v_vld = 1'b0;
        c2v_in  = '0;
        v2c_rdy = 1'b1;
        stall_idx    = -1;
        stall_len    = 0;
        start_in_out = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst busy", busy, 0);
        check("rst c2v_rdy", c2v_rdy, 0);
        check("rst v2c_vld", v2c_vld, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst v2c_idx", v2c_idx, 0);
        check("rst v2c_out_zero", v2c_out == '0, 1);
        check("rst hd_zero", hd_out == '0, 1);
`ifdef VPU_SAT_CNT_EN
        check("rst sat_cnt", sat_cnt, 0);
`endif
        reset = 1'b0;
        tick();

        // Basic column: sum0 = 10, sum1 = -3
        col_deg = 3; llr0 = 5; llr1 = -3;
        c0 = '{2, -4, 7, 0, 0, 0, 0, 0};
        e0 = '{8, 14, 3, 0, 0, 0, 0, 0};
        c1 = '{-5, 6, -1, 0, 0, 0, 0, 0};
        e1 = '{2, -9, -2, 0, 0, 0, 0, 0};
        hd0 = 0; hd1 = 1; exp_sat = 0;
        run_column("basic");

        // Positive saturation: sum0 = 279, sum1 = 1
        col_deg = 8; llr0 = 31; llr1 = 1;
        c0 = '{31, 31, 31, 31, 31, 31, 31, 31};
        e0 = '{31, 31, 31, 31, 31, 31, 31, 31};
        c1 = '{1, 2, 3, 4, -1, -2, -3, -4};
        e1 = '{0, -1, -2, -3, 2, 3, 4, 5};
        hd0 = 0; hd1 = 0; exp_sat = 8;
        run_column("possat");

        // Negative saturation: sum0 = -287, sum1 = -32
        col_deg = 8; llr0 = -31; llr1 = 0;
        c0 = '{-32, -32, -32, -32, -32, -32, -32, -32};
        e0 = '{-31, -31, -31, -31, -31, -31, -31, -31};
        c1 = '{-32, 0, 0, 0, 0, 0, 0, 0};
        e1 = '{0, -31, -31, -31, -31, -31, -31, -31};
        hd0 = 1; hd1 = 1; exp_sat = 15;
        run_column("negsat");

        // Backpressure at idx 1 for 3 cycles: sum0 = -21, sum1 = 10
        col_deg = 3; llr0 = -7; llr1 = 10;
        c0 = '{3, 3, -20, 0, 0, 0, 0, 0};
        e0 = '{-24, -24, -1, 0, 0, 0, 0, 0};
        c1 = '{0, 0, 0, 0, 0, 0, 0, 0};
        e1 = '{10, 10, 10, 0, 0, 0, 0, 0};
        hd0 = 1; hd1 = 0; exp_sat = 0;
        stall_idx = 1; stall_len = 3;
        run_column("stall");
        stall_idx = -1; stall_len = 0;

        // Illegal degrees 0 and 9
        deg = W_DEG'(0); start = 1'b1;
        tick();
        start = 1'b0;
        check("deg0 err", err, 1);
        check("deg0 busy", busy, 0);
        check("deg0 c2v_rdy", c2v_rdy, 0);
        tick();
        check("deg0 err_pulse", err, 0);
        check("deg0 busy_after", busy, 0);
        deg = W_DEG'(9); start = 1'b1;
        tick();
        start = 1'b0;
        check("deg9 err", err, 1);
        check("deg9 busy", busy, 0);
        check("deg9 c2v_rdy", c2v_rdy, 0);
        tick();
        check("deg9 err_pulse", err, 0);
        check("deg9 c2v_rdy_after", c2v_rdy, 0);

        // Reset after 2 of 5 c2v beats; lane0 sum is -30 at that point
        llr_in = '0; c2v_in = '0;
        llr_in[0 +: W_LLR] = W_LLR'(-20);
        deg = W_DEG'(5); start = 1'b1;
        tick();
        start = 1'b0;
        c2v_vld = 1'b1;
        c2v_in[0 +: W_MSG] = W_MSG'(-5);
        tick();
        tick();
        check("abort busy_before", busy, 1);
        check("abort hd0_before", hd_out[0], 1);
        reset = 1'b1;
        c2v_vld = 1'b0;
        tick();
        check("abort busy", busy, 0);
        check("abort c2v_rdy", c2v_rdy, 0);
        check("abort v2c_vld", v2c_vld, 0);
        check("abort hd_zero", hd_out == '0, 1);
        check("abort done", done, 0);
        reset = 1'b0;
        // c2v traffic while idle must be ignored
        c2v_vld = 1'b1;
        c2v_in[0 +: W_MSG] = W_MSG'(17);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort idle_done[%0d]", i), done, 0);
            check($sformatf("abort idle_rdy[%0d]", i), c2v_rdy, 0);
        end
        c2v_vld = 1'b0;

        // Post-reset column with a start pulse during OUT: sum0 = 7, sum1 = -3
        col_deg = 2; llr0 = 4; llr1 = -1;
        c0 = '{9, -6, 0, 0, 0, 0, 0, 0};
        e0 = '{-2, 13, 0, 0, 0, 0, 0, 0};
        c1 = '{-1, -1, 0, 0, 0, 0, 0, 0};
        e1 = '{-2, -2, 0, 0, 0, 0, 0, 0};
        hd0 = 0; hd1 = 1; exp_sat = 0;
        start_in_out = 1'b1;
        run_column("post_reset");
        start_in_out = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
